// File: rtl/cabac_bin_decoder.sv
// Context-adaptive binary arithmetic decoder: decodes one bin per request from a serial bitstream against a 16-entry context table.
// Latency: request handshake at T, bin_valid at T+2 without renormalisation; each renorm bit adds at least one cycle.
// Backpressure: bit source stalls via bit_ready/bit_valid, bin sink holds bin_valid until bin_ready; no new request until the bin is taken.
//
// Ports: clk/rst_n (async active-low); start (new slice), ctx_clear (zero all contexts);
//        bit_in/bit_valid/bit_ready (bitstream in); req_valid/req_ready/req_ctx (decode request);
//        bin_out/bin_valid/bin_ready (decoded bin); ctx_state_out/ctx_mps_out (post-update context);
//        bits_consumed (bits accepted since start); busy (not IDLE/READY).
// Optional build macro CABAC_BYPASS_EN adds req_bypass: equiprobable bins that read one bit and skip the context table.
module cabac_bin_decoder #(
  parameter int NUM_CTX = 16,
  parameter int CTX_W   = $clog2(NUM_CTX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ctx_clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CTX_W-1:0] req_ctx,
`ifdef CABAC_BYPASS_EN
  input  logic             req_bypass,
`endif
  output logic             bin_out,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [2:0]       ctx_state_out,
  output logic             ctx_mps_out,
  output logic [15:0]      bits_consumed,
  output logic             busy
);

  typedef struct packed {
    logic [2:0] state;
    logic       mps;
  } ctx_t;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_READY, S_DECODE, S_RENORM, S_OUTPUT, S_BYPASS
  } fsm_e;

  fsm_e             st, nxt_st;
  logic [8:0]       range_q, offset_q;
  logic [3:0]       init_cnt;
  logic [CTX_W-1:0] ctx_idx;
  ctx_t             ctx_tbl [NUM_CTX];

  ctx_t       cur_ctx, upd_ctx;
  logic [8:0] rlps, rmps, dec_range, dec_offset, sh_offset, sh_range;
  logic       is_lps, dec_bin;
  logic       bit_acc, req_acc, bin_acc;

  // Outputs are registered from nxt_st, so bit_ready/req_ready always
  // mirror the current state and can be used directly as handshake terms.
  assign bit_acc = bit_valid & bit_ready;
  assign req_acc = req_valid & req_ready;
  assign bin_acc = bin_valid & bin_ready;

  always_comb begin
    cur_ctx = ctx_tbl[ctx_idx];
    case (cur_ctx.state)
      3'd0:    rlps = 9'd128;
      3'd1:    rlps = 9'd104;
      3'd2:    rlps = 9'd84;
      3'd3:    rlps = 9'd68;
      3'd4:    rlps = 9'd56;
      3'd5:    rlps = 9'd44;
      3'd6:    rlps = 9'd36;
      default: rlps = 9'd28;
    endcase
    rmps       = range_q - rlps;
    is_lps     = (offset_q >= rmps);
    dec_bin    = is_lps ? ~cur_ctx.mps : cur_ctx.mps;
    dec_range  = is_lps ? rlps : rmps;
    dec_offset = is_lps ? (offset_q - rmps) : offset_q;
    upd_ctx    = cur_ctx;
    if (!is_lps) begin
      if (cur_ctx.state != 3'd7) upd_ctx.state = cur_ctx.state + 3'd1;
    end else if (cur_ctx.state == 3'd0) begin
      upd_ctx.mps = ~cur_ctx.mps;
    end else if (cur_ctx.state <= 3'd3) begin
      upd_ctx.state = cur_ctx.state >> 1;
    end else begin
      upd_ctx.state = cur_ctx.state - 3'd1;
    end
    // 9-bit shifts wrap modulo 512 on non-conforming streams.
    sh_offset = {offset_q[7:0], bit_in};
    sh_range  = {range_q[7:0], 1'b0};
  end

`ifdef CABAC_BYPASS_EN
  logic       bypass_q;
  logic       byp_bin;
  logic [8:0] byp_offset;
  always_comb begin
    byp_bin    = (sh_offset >= range_q);
    byp_offset = byp_bin ? (sh_offset - range_q) : sh_offset;
  end
`endif

  always_comb begin
    nxt_st = st;
    if (start) begin
      nxt_st = S_INIT;
    end else begin
      case (st)
        S_INIT:   if (bit_acc && init_cnt == 4'd8) nxt_st = S_READY;
`ifdef CABAC_BYPASS_EN
        S_READY:  if (req_acc) nxt_st = req_bypass ? S_BYPASS : S_DECODE;
        S_BYPASS: if (bit_acc) nxt_st = S_OUTPUT;
`else
        S_READY:  if (req_acc) nxt_st = S_DECODE;
`endif
        S_DECODE: nxt_st = dec_range[8] ? S_OUTPUT : S_RENORM;
        S_RENORM: if (bit_acc && sh_range[8]) nxt_st = S_OUTPUT;
        S_OUTPUT: if (bin_acc) nxt_st = S_READY;
        default:  nxt_st = st;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= S_IDLE;
      range_q       <= '0;
      offset_q      <= '0;
      init_cnt      <= '0;
      ctx_idx       <= '0;
      bin_out       <= 1'b0;
      ctx_state_out <= '0;
      ctx_mps_out   <= 1'b0;
      bits_consumed <= '0;
      bit_ready     <= 1'b0;
      req_ready     <= 1'b0;
      bin_valid     <= 1'b0;
      busy          <= 1'b0;
`ifdef CABAC_BYPASS_EN
      bypass_q      <= 1'b0;
`endif
      for (int i = 0; i < NUM_CTX; i++) ctx_tbl[i] <= '0;
    end else begin
      st        <= nxt_st;
      bit_ready <= (nxt_st == S_INIT) || (nxt_st == S_RENORM) || (nxt_st == S_BYPASS);
      req_ready <= (nxt_st == S_READY);
      bin_valid <= (nxt_st == S_OUTPUT);
      busy      <= !((nxt_st == S_IDLE) || (nxt_st == S_READY));

      if (start) begin
        range_q       <= 9'd510;
        offset_q      <= '0;
        init_cnt      <= '0;
        bits_consumed <= '0;
      end else begin
        case (st)
          S_INIT: if (bit_acc) begin
            offset_q      <= sh_offset;
            init_cnt      <= init_cnt + 4'd1;
            bits_consumed <= bits_consumed + 16'd1;
          end
          S_READY: if (req_acc) begin
            ctx_idx <= req_ctx;
`ifdef CABAC_BYPASS_EN
            bypass_q <= req_bypass;
`endif
          end
          S_DECODE: begin
            range_q       <= dec_range;
            offset_q      <= dec_offset;
            bin_out       <= dec_bin;
            ctx_state_out <= upd_ctx.state;
            ctx_mps_out   <= upd_ctx.mps;
          end
          S_RENORM: if (bit_acc) begin
            range_q       <= sh_range;
            offset_q      <= sh_offset;
            bits_consumed <= bits_consumed + 16'd1;
          end
`ifdef CABAC_BYPASS_EN
          S_BYPASS: if (bit_acc) begin
            offset_q      <= byp_offset;
            bin_out       <= byp_bin;
            bits_consumed <= bits_consumed + 16'd1;
          end
`endif
          default: ;
        endcase
      end

      // A clear overrides a same-cycle write-back. The write-back itself
      // is not cancelled by start: the decision was already made.
      if (ctx_clear) begin
        for (int i = 0; i < NUM_CTX; i++) ctx_tbl[i] <= '0;
      end else if (st == S_DECODE) begin
        ctx_tbl[ctx_idx] <= upd_ctx;
      end
    end
  end

endmodule

// File: tb/tb_cabac_bin_decoder.sv
// Bench for cabac_bin_decoder: drives slices and decode requests, checks each bin against an arithmetic reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cabac_bin_decoder;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        start = 1'b0, ctx_clear = 1'b0;
  logic        bit_in = 1'b0, bit_valid = 1'b0, req_valid = 1'b0, bin_ready = 1'b0;
  logic [3:0]  req_ctx = '0;
  logic        bit_ready, req_ready, bin_out, bin_valid, ctx_mps_out, busy;
  logic [2:0]  ctx_state_out;
  logic [15:0] bits_consumed;

  always #5 clk = ~clk;

  cabac_bin_decoder #(.NUM_CTX(16), .CTX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctx_clear(ctx_clear),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctx(req_ctx),
`ifdef CABAC_BYPASS_EN
    .req_bypass(1'b0),
`endif
    .bin_out(bin_out), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .ctx_state_out(ctx_state_out), .ctx_mps_out(ctx_mps_out),
    .bits_consumed(bits_consumed), .busy(busy)
  );

  int total = 0, bad = 0;

  // Reference model: interval arithmetic on plain integers.
  int m_range = 0, m_off = 0, m_bits = 0;
  int m_state [16];
  int m_mps   [16];
  int bitq [$];
  bit zero_fill = 1'b0;
  int rlps_tab [8] = '{128, 104, 84, 68, 56, 44, 36, 28};

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin m_state[i] = 0; m_mps[i] = 0; end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
    m_range = 510; m_off = 0; m_bits = 0;
  endtask

  task automatic pulse_clear();
    ctx_clear = 1'b1; @(negedge clk); ctx_clear = 1'b0;
    model_clear();
  endtask

  task automatic feed_bits(input logic [8:0] pat, input bit rnd);
    int n = 0;
    int guard = 0;
    logic b;
    while (n < 9 && guard < 200) begin
      if (bit_ready === 1'b1 && (!rnd || $urandom_range(0, 3) != 0)) begin
        b = rnd ? ($urandom_range(0, 1) == 1) : pat[8-n];
        bit_valid = 1'b1; bit_in = b;
        m_off = (m_off * 2 + int'(b)) % 512; m_bits++; n++;
      end else begin
        bit_valid = 1'b0; bit_in = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk); guard++;
    end
    bit_valid = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL init_ready got=%b want=1", req_ready); end
    total++; if (bits_consumed !== 16'(m_bits)) begin bad++; $display("FAIL init_bits got=%0d want=%0d", bits_consumed, m_bits); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_busy got=%b want=0", busy); end
  endtask

  task automatic load_slice(input logic [8:0] pat, input bit rnd);
    pulse_start();
    feed_bits(pat, rnd);
  endtask

  // One request from READY through bin acceptance, checked against the model.
  task automatic decode_one(input int c, input int stall, input int hold, input bit clr_mid, output int ebin);
    int s, m, rm, lat, idx, st_cnt, k, exp_lat;
    int rb [$];
    while (bitq.size() < 16) bitq.push_back(zero_fill ? 0 : int'($urandom_range(0, 1)));
    s = m_state[c]; m = m_mps[c];
    rm = m_range - rlps_tab[s];
    if (m_off >= rm) begin
      ebin = 1 - m; m_off = m_off - rm; m_range = rlps_tab[s];
      if (s == 0) m = 1 - m;
      else if (s <= 3) s = s / 2;
      else s = s - 1;
    end else begin
      ebin = m; m_range = rm;
      if (s < 7) s = s + 1;
    end
    m_state[c] = s; m_mps[c] = m;
    if (clr_mid) model_clear();
    while (m_range < 256) begin
      rb.push_back(bitq.pop_front());
      m_range = m_range * 2;
      m_off = (m_off * 2 + rb[rb.size()-1]) % 512;
    end
    k = rb.size();
    exp_lat = 2 + k * (stall + 1);

    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_pre ctx=%0d got=%b want=1", c, req_ready); end
    req_ctx = 4'(c); req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_ctx = 4'($urandom_range(0, 15));
    lat = 1; idx = 0; st_cnt = 0;
    while (bin_valid !== 1'b1 && lat < 300) begin
      ctx_clear = (lat == 1 && clr_mid);
      if (bit_ready === 1'b1) begin
        if (st_cnt < stall) begin
          bit_valid = 1'b0; st_cnt++;
          total++; if (bits_consumed !== 16'(m_bits + idx)) begin bad++; $display("FAIL stall_bits got=%0d want=%0d", bits_consumed, m_bits + idx); end
          total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", busy); end
        end else begin
          bit_valid = 1'b1; bit_in = (idx < k) ? (rb[idx] != 0) : 1'b0;
          idx++; st_cnt = 0;
        end
      end else begin
        bit_valid = 1'b0;
      end
      @(negedge clk); lat++;
    end
    bit_valid = 1'b0; ctx_clear = 1'b0;
    m_bits += k;

    total++; if (lat != exp_lat) begin bad++; $display("FAIL latency ctx=%0d got=%0d want=%0d", c, lat, exp_lat); end
    total++; if (bin_out !== 1'(ebin)) begin bad++; $display("FAIL bin ctx=%0d got=%b want=%0d", c, bin_out, ebin); end
    total++; if (ctx_state_out !== 3'(s)) begin bad++; $display("FAIL ctx_state ctx=%0d got=%0d want=%0d", c, ctx_state_out, s); end
    total++; if (ctx_mps_out !== 1'(m)) begin bad++; $display("FAIL ctx_mps ctx=%0d got=%b want=%0d", c, ctx_mps_out, m); end
    total++; if (bits_consumed !== 16'(m_bits)) begin bad++; $display("FAIL bits ctx=%0d got=%0d want=%0d", c, bits_consumed, m_bits); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL output_busy got=%b want=1", busy); end
    for (int h = 0; h < hold; h++) begin
      bin_ready = 1'b0; @(negedge clk);
      total++;
      if (bin_valid !== 1'b1 || bin_out !== 1'(ebin) || req_ready !== 1'b0) begin
        bad++; $display("FAIL hold cyc=%0d got vld=%b bin=%b rdy=%b want vld=1 bin=%0d rdy=0", h, bin_valid, bin_out, req_ready, ebin);
      end
    end
    bin_ready = 1'b1; @(negedge clk); bin_ready = 1'b0;
    total++;
    if (bin_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL release got vld=%b rdy=%b busy=%b want 0/1/0", bin_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    total++;
    if ({bin_valid, bin_out, bit_ready, req_ready, busy, ctx_mps_out, ctx_state_out, bits_consumed} !== '0) begin
      bad++; $display("FAIL reset_outputs got vld=%b bin=%b brdy=%b rrdy=%b busy=%b st=%0d mps=%b bits=%0d want all 0",
                      bin_valid, bin_out, bit_ready, req_ready, busy, ctx_state_out, ctx_mps_out, bits_consumed);
    end
    rst_n = 1'b1;
    // Traffic while IDLE must be ignored.
    bit_valid = 1'b1; bit_in = 1'b1; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    bit_valid = 1'b0; req_valid = 1'b0;
    total++;
    if (bit_ready !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b0 || bits_consumed !== 16'd0 || bin_valid !== 1'b0) begin
      bad++; $display("FAIL idle_ignore got brdy=%b rrdy=%b busy=%b bits=%0d vld=%b want 0", bit_ready, req_ready, busy, bits_consumed, bin_valid);
    end
  endtask

  task automatic test_init();
    pulse_start();
    total++; if (bit_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL init_entry got brdy=%b busy=%b want 1/1", bit_ready, busy); end
    feed_bits(9'b000000000, 1'b0);
  endtask

  task automatic test_mps_path();
    int b;
    decode_one(0, 0, 0, 1'b0, b);
    total++; if (bin_out !== 1'b0 || ctx_state_out !== 3'd1 || ctx_mps_out !== 1'b0) begin
      bad++; $display("FAIL mps_fixed got bin=%b st=%0d mps=%b want 0/1/0", bin_out, ctx_state_out, ctx_mps_out);
    end
  endtask

  task automatic test_lps_renorm();
    int b;
    pulse_clear();
    load_slice(9'b110000000, 1'b0);
    bitq.delete(); bitq.push_back(1);
    decode_one(0, 0, 0, 1'b0, b);
    total++; if (bin_out !== 1'b1 || ctx_state_out !== 3'd0 || ctx_mps_out !== 1'b1 || bits_consumed !== 16'd10) begin
      bad++; $display("FAIL lps_fixed got bin=%b st=%0d mps=%b bits=%0d want 1/0/1/10", bin_out, ctx_state_out, ctx_mps_out, bits_consumed);
    end
    // Follow-on decode exercises the post-renorm range 256 / offset 5.
    decode_one(0, 0, 0, 1'b0, b);
  endtask

  task automatic test_stall_backpressure();
    int b;
    load_slice(9'b110000000, 1'b0);
    decode_one(5, 3, 5, 1'b0, b);
  endtask

  task automatic test_saturation();
    int b;
    zero_fill = 1'b1; bitq.delete();
    load_slice(9'b000000000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      decode_one(3, 0, 0, 1'b0, b);
      total++; if (ctx_state_out !== 3'((i + 1 > 7) ? 7 : i + 1) || bin_out !== 1'b0) begin
        bad++; $display("FAIL sat_state i=%0d got st=%0d bin=%b want st=%0d bin=0", i, ctx_state_out, bin_out, (i + 1 > 7) ? 7 : i + 1);
      end
    end
    zero_fill = 1'b0; bitq.delete();
    load_slice(9'b111111100, 1'b0);
    decode_one(3, 0, 0, 1'b0, b);
    total++; if (ctx_state_out !== 3'd6 || bin_out !== 1'b1) begin
      bad++; $display("FAIL sat_lps got st=%0d bin=%b want 6/1", ctx_state_out, bin_out);
    end
  endtask

  task automatic test_abort_clear();
    int b;
    load_slice(9'b110000000, 1'b0);
    req_ctx = 4'd7; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    repeat (3) begin
      total++; if (bit_ready !== 1'b1 || bin_valid !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL renorm_wait got brdy=%b vld=%b busy=%b want 1/0/1", bit_ready, bin_valid, busy);
      end
      @(negedge clk);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    m_state[7] = 0; m_mps[7] = 1;
    m_range = 510; m_off = 0; m_bits = 0;
    total++; if (bits_consumed !== 16'd0 || bit_ready !== 1'b1 || bin_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL abort got bits=%0d brdy=%b vld=%b rrdy=%b want 0/1/0/0", bits_consumed, bit_ready, bin_valid, req_ready);
    end
    repeat (4) begin
      @(negedge clk);
      total++; if (bin_valid !== 1'b0) begin bad++; $display("FAIL abort_no_bin got=%b want=0", bin_valid); end
    end
    feed_bits(9'b000000000, 1'b0);
    pulse_clear();
    decode_one(3, 0, 0, 1'b0, b);
    total++; if (ctx_state_out !== 3'd1 || ctx_mps_out !== 1'b0) begin
      bad++; $display("FAIL clear_ctx3 got st=%0d mps=%b want 1/0", ctx_state_out, ctx_mps_out);
    end
  endtask

  task automatic test_clear_wins();
    int b;
    decode_one(3, 0, 0, 1'b1, b);
    decode_one(3, 0, 0, 1'b0, b);
    total++; if (ctx_state_out !== 3'd1 || ctx_mps_out !== 1'b0) begin
      bad++; $display("FAIL clear_wins got st=%0d mps=%b want 1/0", ctx_state_out, ctx_mps_out);
    end
  endtask

  task automatic test_back_to_back();
    int b;
    load_slice(9'b0, 1'b1);
    for (int i = 0; i < 6; i++) decode_one(int'($urandom_range(0, 15)), 0, 0, 1'b0, b);
  endtask

  task automatic test_random();
    int b;
    for (int sl = 0; sl < 4; sl++) begin
      load_slice(9'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 7) == 0) pulse_clear();
        decode_one(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_mps_path();
    test_lps_renorm();
    test_stall_backpressure();
    test_saturation();
    test_abort_clear();
    test_clear_wins();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
